// File: rtl/gpio_controller_intr_status_pkg.sv
// ---------------------------------------------------------------------------
// gpio_controller_pkg
//   Shared types and defaults for the GPIO interrupt status / coalescing slice.
//   intr_state_e : state of the interrupt coalescing FSM (also the debug view)
//   GPIO_*       : default widths used by the interface and the modules
// ---------------------------------------------------------------------------
package gpio_controller_pkg;

  typedef enum logic [1:0] {
    INTR_IDLE    = 2'd0,
    INTR_HOLDOFF = 2'd1,
    INTR_ASSERT  = 2'd2
  } intr_state_e;

  localparam int GPIO_NUM_BANKS  = 8;
  localparam int GPIO_COALESCE_W = 16;
  localparam int GPIO_COUNT_W    = 16;

endpackage

// File: rtl/gpio_controller_intr_status_if.sv
// ---------------------------------------------------------------------------
// gpio_controller_intr_status_if
//   Software-facing register bus of the interrupt status block.
//   master : software side (drives W1C strobe, masks, holdoff, count clear;
//            reads back status and interrupt count)
//   slave  : the controller
//
// Handshake: status_wr_en is a one-cycle strobe with no ready; the controller
// accepts every strobe in the cycle it is presented, qualified by
// status_wr_sel/status_wr_data in that same cycle. Masks, coalesce_cycles and
// intr_count_clr are plain level inputs sampled every cycle.
// ---------------------------------------------------------------------------
interface gpio_controller_intr_status_if
  import gpio_controller_pkg::*;
#(
  parameter int NUM_BANKS  = GPIO_NUM_BANKS,
  parameter int COALESCE_W = GPIO_COALESCE_W,
  parameter int COUNT_W    = GPIO_COUNT_W
) ();

  logic                  status_wr_en;
  logic                  status_wr_sel;
  logic [NUM_BANKS-1:0]  status_wr_data;
  logic [NUM_BANKS-1:0]  posedge_intr_mask;
  logic [NUM_BANKS-1:0]  negedge_intr_mask;
  logic [COALESCE_W-1:0] coalesce_cycles;
  logic                  intr_count_clr;
  logic [NUM_BANKS-1:0]  posedge_intr_status;
  logic [NUM_BANKS-1:0]  negedge_intr_status;
  logic [COUNT_W-1:0]    intr_count;

  modport master (
    output status_wr_en, status_wr_sel, status_wr_data,
    output posedge_intr_mask, negedge_intr_mask,
    output coalesce_cycles, intr_count_clr,
    input  posedge_intr_status, negedge_intr_status, intr_count
  );

  modport slave (
    input  status_wr_en, status_wr_sel, status_wr_data,
    input  posedge_intr_mask, negedge_intr_mask,
    input  coalesce_cycles, intr_count_clr,
    output posedge_intr_status, negedge_intr_status, intr_count
  );

endinterface

// File: rtl/gpio_controller_intr_coalesce.sv
// ---------------------------------------------------------------------------
// gpio_controller_intr_coalesce
//   Interrupt coalescing FSM, holdoff counter and saturating assertion count.
//   clk, rst_n      : clock, asynchronous active-low reset
//   pending         : at least one unmasked sticky status bit is set
//   coalesce_cycles : holdoff length, sampled only when entering HOLDOFF
//   intr_count_clr  : synchronous clear of intr_count (wins over increment)
//   intr_out        : registered level interrupt, high exactly in ASSERT
//   intr_count      : saturating count of entries into ASSERT
//   state           : FSM state, for debug visibility
// ---------------------------------------------------------------------------
module gpio_controller_intr_coalesce
  import gpio_controller_pkg::*;
#(
  parameter int COALESCE_W = GPIO_COALESCE_W,
  parameter int COUNT_W    = GPIO_COUNT_W
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  pending,
  input  logic [COALESCE_W-1:0] coalesce_cycles,
  input  logic                  intr_count_clr,
  output logic                  intr_out,
  output logic [COUNT_W-1:0]    intr_count,
  output intr_state_e           state
);

  intr_state_e           state_q;
  logic [COALESCE_W-1:0] holdoff_q;
  logic [COUNT_W-1:0]    intr_count_q;
  logic                  intr_out_q;
  logic                  enter_assert;

  // Mirrors the two FSM arcs into ASSERT; used only to step the counter.
  assign enter_assert = pending &&
                        (((state_q == INTR_IDLE)    && (coalesce_cycles == '0)) ||
                         ((state_q == INTR_HOLDOFF) && (holdoff_q == COALESCE_W'(1))));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= INTR_IDLE;
      holdoff_q  <= '0;
      intr_out_q <= 1'b0;
    end else begin
      case (state_q)
        INTR_IDLE: begin
          if (pending) begin
            if (coalesce_cycles == '0) begin
              state_q    <= INTR_ASSERT;
              intr_out_q <= 1'b1;
            end else begin
              state_q   <= INTR_HOLDOFF;
              holdoff_q <= coalesce_cycles;
            end
          end
        end
        INTR_HOLDOFF: begin
          if (!pending) begin
            state_q   <= INTR_IDLE;
            holdoff_q <= '0;
          end else if (holdoff_q == COALESCE_W'(1)) begin
            state_q    <= INTR_ASSERT;
            holdoff_q  <= '0;
            intr_out_q <= 1'b1;
          end else begin
            holdoff_q <= holdoff_q - COALESCE_W'(1);
          end
        end
        INTR_ASSERT: begin
          if (!pending) begin
            state_q    <= INTR_IDLE;
            intr_out_q <= 1'b0;
          end
        end
        default: begin
          state_q    <= INTR_IDLE;
          holdoff_q  <= '0;
          intr_out_q <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      intr_count_q <= '0;
    end else if (intr_count_clr) begin
      intr_count_q <= '0;
    end else if (enter_assert && (intr_count_q != '1)) begin
      intr_count_q <= intr_count_q + COUNT_W'(1);
    end
  end

  assign intr_out   = intr_out_q;
  assign intr_count = intr_count_q;
  assign state      = state_q;

endmodule

// File: rtl/gpio_controller_intr_status.sv
// ---------------------------------------------------------------------------
// gpio_controller_intr_status
//   Sticky posedge/negedge interrupt status with write-1-to-clear, per-bank
//   masking and a coalesced level interrupt.
//   clk, rst_n               : clock, asynchronous active-low reset
//   posedge_intr_status_set  : 1-cycle set pulses per bank
//   negedge_intr_status_set  : 1-cycle set pulses per bank
//   sw                       : software register bus (W1C, masks, holdoff,
//                              count clear; status and count readback)
//   intr_out                 : registered level interrupt
//   intr_state               : coalescing FSM state, for debug visibility
// ---------------------------------------------------------------------------
module gpio_controller_intr_status
  import gpio_controller_pkg::*;
#(
  parameter int NUM_BANKS  = GPIO_NUM_BANKS,
  parameter int COALESCE_W = GPIO_COALESCE_W,
  parameter int COUNT_W    = GPIO_COUNT_W
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NUM_BANKS-1:0]  posedge_intr_status_set,
  input  logic [NUM_BANKS-1:0]  negedge_intr_status_set,
  gpio_controller_intr_status_if.slave sw,
  output logic                  intr_out,
  output intr_state_e           intr_state
);

  logic [NUM_BANKS-1:0] pos_status_q;
  logic [NUM_BANKS-1:0] neg_status_q;
  logic [NUM_BANKS-1:0] pos_clr;
  logic [NUM_BANKS-1:0] neg_clr;
  logic                 pending;

  assign pos_clr = {NUM_BANKS{sw.status_wr_en & ~sw.status_wr_sel}} & sw.status_wr_data;
  assign neg_clr = {NUM_BANKS{sw.status_wr_en &  sw.status_wr_sel}} & sw.status_wr_data;

  // Set is OR-ed in after the clear so a same-cycle set survives a W1C.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pos_status_q <= '0;
      neg_status_q <= '0;
    end else begin
      pos_status_q <= (pos_status_q & ~pos_clr) | posedge_intr_status_set;
      neg_status_q <= (neg_status_q & ~neg_clr) | negedge_intr_status_set;
    end
  end

  // Masks act combinationally, so unmasking a set bit behaves like a new set.
  assign pending = (|(pos_status_q & ~sw.posedge_intr_mask)) |
                   (|(neg_status_q & ~sw.negedge_intr_mask));

  gpio_controller_intr_coalesce #(
    .COALESCE_W (COALESCE_W),
    .COUNT_W    (COUNT_W)
  ) u_coalesce (
    .clk             (clk),
    .rst_n           (rst_n),
    .pending         (pending),
    .coalesce_cycles (sw.coalesce_cycles),
    .intr_count_clr  (sw.intr_count_clr),
    .intr_out        (intr_out),
    .intr_count      (sw.intr_count),
    .state           (intr_state)
  );

  assign sw.posedge_intr_status = pos_status_q;
  assign sw.negedge_intr_status = neg_status_q;

endmodule

// File: tb/tb_gpio_controller_intr_status.sv
// ---------------------------------------------------------------------------
// tb_gpio_controller_intr_status
//   Directed bench: the driver schedules hand-computed expectations for
//   specific cycles into a queue; a negedge monitor pops and compares them.
// ---------------------------------------------------------------------------
module tb_gpio_controller_intr_status;
  import gpio_controller_pkg::*;

  localparam int K_POS   = 0;
  localparam int K_NEG   = 1;
  localparam int K_INTR  = 2;
  localparam int K_CNT   = 3;
  localparam int K_STATE = 4;

  typedef struct {
    int          cyc;
    int          kind;
    logic [31:0] val;
    string       nm;
  } exp_t;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- DUT ----------------
  logic [7:0]  pos_set;
  logic [7:0]  neg_set;
  logic        intr_out;
  intr_state_e intr_state;

  gpio_controller_intr_status_if sw_if ();

  gpio_controller_intr_status dut (
    .clk                     (clk),
    .rst_n                   (rst_n),
    .posedge_intr_status_set (pos_set),
    .negedge_intr_status_set (neg_set),
    .sw                      (sw_if),
    .intr_out                (intr_out),
    .intr_state              (intr_state)
  );

  // ---------------- scoreboard ----------------
  exp_t exp_q[$];
  int   vectors = 0;
  int   miscompares = 0;

  function automatic logic [31:0] actual(int kind);
    case (kind)
      K_POS:   return {24'b0, sw_if.posedge_intr_status};
      K_NEG:   return {24'b0, sw_if.negedge_intr_status};
      K_INTR:  return {31'b0, intr_out};
      K_CNT:   return {16'b0, sw_if.intr_count};
      default: return 32'(intr_state);
    endcase
  endfunction

  always @(negedge clk) begin
    for (int i = exp_q.size() - 1; i >= 0; i--) begin
      if (exp_q[i].cyc <= cyc) begin
        vectors++;
        if (exp_q[i].cyc < cyc) begin
          miscompares++;
          $display("FAIL %s: check for cycle %0d missed at cycle %0d", exp_q[i].nm, exp_q[i].cyc, cyc);
        end else if (actual(exp_q[i].kind) !== exp_q[i].val) begin
          miscompares++;
          $display("FAIL %s @cycle %0d: got %0h expected %0h",
                   exp_q[i].nm, cyc, actual(exp_q[i].kind), exp_q[i].val);
        end
        exp_q.delete(i);
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic expect_at(input int c, input int kind, input logic [31:0] v, input string nm);
    exp_t e;
    e.cyc = c; e.kind = kind; e.val = v; e.nm = nm;
    exp_q.push_back(e);
  endtask

  task automatic expect_range(input int c0, input int c1, input int kind, input logic [31:0] v,
                              input string nm);
    for (int c = c0; c <= c1; c++) expect_at(c, kind, v, nm);
  endtask

  // One-cycle W1C strobe in the current cycle.
  task automatic w1c(input logic sel, input logic [7:0] data);
    sw_if.status_wr_en   = 1'b1;
    sw_if.status_wr_sel  = sel;
    sw_if.status_wr_data = data;
    tick();
    sw_if.status_wr_en   = 1'b0;
    sw_if.status_wr_data = 8'h00;
  endtask

  // Posedge pulse on bank 0 with coalesce 0; clears it afterwards.
  task automatic episode(input logic [31:0] cnt_exp, input string nm);
    int n;
    n = cyc;
    pos_set = 8'h01;
    expect_at(n + 2, K_INTR, 1, {nm, "_intr"});
    expect_at(n + 2, K_CNT, cnt_exp, {nm, "_cnt"});
    tick();
    pos_set = 8'h00;
    tick();
    w1c(1'b0, 8'h01);
    expect_at(n + 4, K_INTR, 0, {nm, "_drop"});
    tick(2);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int n, m, k, j, q;
    pos_set = 8'h00;
    neg_set = 8'h00;
    sw_if.status_wr_en      = 1'b0;
    sw_if.status_wr_sel     = 1'b0;
    sw_if.status_wr_data    = 8'h00;
    sw_if.posedge_intr_mask = 8'h00;
    sw_if.negedge_intr_mask = 8'h00;
    sw_if.coalesce_cycles   = 16'd0;
    sw_if.intr_count_clr    = 1'b0;

    // reset values
    tick(2);
    expect_at(cyc, K_POS, 0, "rst_pos");
    expect_at(cyc, K_NEG, 0, "rst_neg");
    expect_at(cyc, K_INTR, 0, "rst_intr");
    expect_at(cyc, K_CNT, 0, "rst_cnt");
    expect_at(cyc, K_STATE, 32'(INTR_IDLE), "rst_state");
    tick();
    rst_n = 1'b1;
    tick(2);

    // 1: posedge set, no holdoff
    n = cyc;
    pos_set = 8'h04;
    expect_at(n + 1, K_POS, 8'h04, "t1_pos_status");
    expect_at(n + 1, K_INTR, 0, "t1_intr_n1");
    expect_at(n + 2, K_INTR, 1, "t1_intr_n2");
    expect_at(n + 2, K_CNT, 1, "t1_count");
    expect_at(n + 2, K_STATE, 32'(INTR_ASSERT), "t1_state");
    tick();
    pos_set = 8'h00;
    tick(2);

    // 2: W1C drops status and interrupt; set beats same-cycle clear
    m = cyc;
    w1c(1'b0, 8'h04);
    expect_at(m + 1, K_POS, 0, "t2_pos_cleared");
    expect_at(m + 2, K_INTR, 0, "t2_intr_low");
    expect_at(m + 2, K_STATE, 32'(INTR_IDLE), "t2_state");
    tick(2);
    sw_if.negedge_intr_mask = 8'hFF;
    n = cyc;
    neg_set = 8'h01;
    expect_at(n + 1, K_NEG, 8'h01, "t2_neg_set");
    tick();
    neg_set = 8'h01;
    sw_if.status_wr_en   = 1'b1;
    sw_if.status_wr_sel  = 1'b1;
    sw_if.status_wr_data = 8'h01;
    expect_at(n + 2, K_NEG, 8'h01, "t2_set_beats_clr");
    tick();
    neg_set = 8'h00;
    expect_at(n + 3, K_NEG, 0, "t2_neg_w1c");
    tick();
    sw_if.status_wr_en   = 1'b0;
    sw_if.status_wr_data = 8'h00;
    sw_if.negedge_intr_mask = 8'h00;
    expect_at(n + 4, K_INTR, 0, "t2_masked_intr");
    expect_at(n + 4, K_CNT, 1, "t2_count");
    tick(2);

    // 3: holdoff of 5; change of coalesce mid-holdoff is ignored
    sw_if.coalesce_cycles = 16'd5;
    n = cyc;
    neg_set = 8'h80;
    expect_at(n + 1, K_NEG, 8'h80, "t3_neg_status");
    expect_range(n + 1, n + 6, K_INTR, 0, "t3_intr_holdoff");
    expect_at(n + 2, K_STATE, 32'(INTR_HOLDOFF), "t3_state_holdoff");
    expect_at(n + 7, K_INTR, 1, "t3_intr_n7");
    expect_at(n + 7, K_CNT, 2, "t3_count");
    tick();
    neg_set = 8'h00;
    tick(2);
    sw_if.coalesce_cycles = 16'd1;
    tick(5);
    k = cyc;
    w1c(1'b1, 8'h80);
    expect_at(k + 2, K_INTR, 0, "t3_intr_drop");
    expect_at(k + 2, K_STATE, 32'(INTR_IDLE), "t3_state_idle");
    tick(2);

    // 3b: W1C during holdoff cancels the interrupt
    sw_if.coalesce_cycles = 16'd5;
    n = cyc;
    neg_set = 8'h80;
    expect_range(n + 1, n + 10, K_INTR, 0, "t3b_intr_never");
    expect_at(n + 5, K_STATE, 32'(INTR_HOLDOFF), "t3b_state_holdoff");
    expect_at(n + 5, K_NEG, 0, "t3b_neg_cleared");
    expect_at(n + 6, K_STATE, 32'(INTR_IDLE), "t3b_state_idle");
    expect_at(n + 10, K_CNT, 2, "t3b_count");
    tick();
    neg_set = 8'h00;
    tick(3);
    w1c(1'b1, 8'h80);
    tick(6);

    // 4: masking and unmasking
    sw_if.coalesce_cycles   = 16'd0;
    sw_if.posedge_intr_mask = 8'hFF;
    n = cyc;
    pos_set = 8'h10;
    expect_at(n + 1, K_POS, 8'h10, "t4_pos_status");
    expect_range(n + 1, n + 3, K_INTR, 0, "t4_masked");
    tick();
    pos_set = 8'h00;
    tick(2);
    sw_if.posedge_intr_mask = 8'h00;
    expect_at(n + 4, K_INTR, 1, "t4_unmask_intr");
    expect_at(n + 4, K_CNT, 3, "t4_count");
    tick(3);
    j = cyc;
    sw_if.posedge_intr_mask = 8'hFF;
    expect_at(j + 1, K_INTR, 0, "t4_remask_low");
    expect_at(j + 1, K_POS, 8'h10, "t4_status_kept");
    tick(2);
    expect_at(cyc + 1, K_POS, 0, "t4_pos_cleared");
    w1c(1'b0, 8'h10);
    sw_if.posedge_intr_mask = 8'h00;
    tick(2);

    // 5: saturation and clear priority
    force dut.u_coalesce.intr_count_q = 16'hFFFE;
    @(negedge clk);
    release dut.u_coalesce.intr_count_q;
    tick();
    expect_at(cyc, K_CNT, 16'hFFFE, "t5_preload");
    tick();
    episode(16'hFFFF, "t5_ep1");
    episode(16'hFFFF, "t5_ep2_sat");
    q = cyc;
    pos_set = 8'h01;
    tick();
    pos_set = 8'h00;
    sw_if.intr_count_clr = 1'b1;
    expect_at(q + 2, K_CNT, 0, "t5_clr_priority");
    expect_at(q + 2, K_INTR, 1, "t5_clr_intr");
    tick();
    sw_if.intr_count_clr = 1'b0;
    expect_at(q + 3, K_CNT, 0, "t5_clr_hold");
    w1c(1'b0, 8'h01);
    tick(2);
    episode(1, "t6_pre");

    // 6: async reset during holdoff
    sw_if.coalesce_cycles = 16'd100;
    n = cyc;
    pos_set = 8'h3C;
    expect_at(n + 2, K_POS, 8'h3C, "t6_pos_status");
    expect_at(n + 2, K_STATE, 32'(INTR_HOLDOFF), "t6_state_holdoff");
    expect_at(n + 2, K_CNT, 1, "t6_count_before");
    tick();
    pos_set = 8'h00;
    tick(2);
    #1 rst_n = 1'b0;
    expect_at(n + 3, K_POS, 0, "t6_rst_pos");
    expect_at(n + 3, K_NEG, 0, "t6_rst_neg");
    expect_at(n + 3, K_INTR, 0, "t6_rst_intr");
    expect_at(n + 3, K_CNT, 0, "t6_rst_cnt");
    expect_at(n + 3, K_STATE, 32'(INTR_IDLE), "t6_rst_state");
    tick();
    rst_n = 1'b1;
    expect_range(n + 4, n + 12, K_INTR, 0, "t6_no_intr");
    expect_at(n + 12, K_POS, 0, "t6_pos_after");
    expect_at(n + 12, K_STATE, 32'(INTR_IDLE), "t6_state_after");
    tick(12);

    // report
    tick(2);
    while (exp_q.size() > 0) begin
      vectors++;
      miscompares++;
      $display("FAIL %s: check for cycle %0d never reached", exp_q[0].nm, exp_q[0].cyc);
      void'(exp_q.pop_front());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    miscompares++;
    $display("FAIL watchdog: stimulus did not complete by %0t", $time);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
